// File: rtl/uart_pkg.sv
// Shared UART definitions: tx state encoding, parity selectors and default widths.
// The receive side imports the same package.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_PRESCALE_WIDTH = 5;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit prescale counter: counts 0..term, flags the terminal cycle and wraps.
// A clear restarts the count at 0 on the next edge.
module uart_tx_bit_timer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [WIDTH-1:0] term,
   output logic             last_cycle
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || last_cycle) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + WIDTH'(1);
      end
   end

   assign last_cycle = (cnt == term);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop; each bit PRESCALE cycles.
// Define UART_TX_TWO_STOP_EN for two stop bits; default build sends one.
//
// state  | meaning
// IDLE   | line high, ready to accept a byte
// START  | driving the start bit (low)
// DATA   | shifting payload bits, LSB first
// PARITY | driving the latched parity bit
// STOP   | driving stop bit(s); BUSY drops in the final cycle
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      DATA_VALID,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
   output logic                      TX_OUT,
   output logic                      BUSY
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   tx_state_t                 state, state_n;
   logic [IDX_W-1:0]          bit_idx, bit_idx_n;
   logic [DATA_WIDTH-1:0]     shreg, shreg_n;
   logic                      par_en_l, par_bit_l;
   logic [PRESCALE_WIDTH-1:0] prescale_l;
   logic                      tx_q, tx_n;
   logic                      last_cycle, stop_last, accept, busy, timer_clear;

   uart_tx_bit_timer #(.WIDTH(PRESCALE_WIDTH)) u_bit_timer (
      .clk        (CLK),
      .rst_n      (RST),
      .clear      (timer_clear),
      .term       (prescale_l - PRESCALE_WIDTH'(1)),
      .last_cycle (last_cycle)
   );

`ifdef UART_TX_TWO_STOP_EN
   logic stop_idx;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stop_idx <= 1'b0;
      end else begin
         stop_idx <= (state == STOP) && (stop_idx || last_cycle);
      end
   end

   assign stop_last = stop_idx;
`else
   assign stop_last = 1'b1;
`endif

   // Early release lets the next byte be accepted in the last stop cycle.
   assign busy        = (state != IDLE) && !((state == STOP) && last_cycle && stop_last);
   assign accept      = DATA_VALID && !busy;
   assign timer_clear = accept || (state == IDLE);

   always_comb begin
      state_n   = state;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      tx_n      = tx_q;
      case (state)
         IDLE:   if (accept) state_n = START;
         START:  if (last_cycle) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                 end
         DATA:   if (last_cycle) begin
                    if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                       state_n = par_en_l ? PARITY : STOP;
                    end else begin
                       bit_idx_n = bit_idx + IDX_W'(1);
                       shreg_n   = shreg >> 1;
                    end
                 end
         PARITY: if (last_cycle) state_n = STOP;
         STOP:   if (last_cycle && stop_last) state_n = accept ? START : IDLE;
         default: state_n = IDLE;
      endcase
      if (accept) shreg_n = P_DATA;
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shreg_n[0];
         PARITY:  tx_n = par_bit_l;
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         bit_idx    <= '0;
         shreg      <= '0;
         par_en_l   <= 1'b0;
         par_bit_l  <= 1'b0;
         prescale_l <= PRESCALE_WIDTH'(1);
         tx_q       <= 1'b1;
      end else begin
         state   <= state_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
         tx_q    <= tx_n;
         if (accept) begin
            par_en_l   <= PAR_EN;
            par_bit_l  <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
            prescale_l <= (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
         end
      end
   end

   assign TX_OUT = tx_q;
   assign BUSY   = busy;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: a frame-level model queues the expected line/BUSY
// value per cycle and a monitor compares every cycle against it.
module tb_uart_tx;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] P_DATA = '0;
   logic       DATA_VALID = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [4:0] PRESCALE = '0;
   logic       TX_OUT, BUSY;

`ifdef UART_TX_TWO_STOP_EN
   localparam int N_STOP = 2;
`else
   localparam int N_STOP = 1;
`endif

   uart_tx dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .PRESCALE   (PRESCALE),
      .TX_OUT     (TX_OUT),
      .BUSY       (BUSY)
   );

   always #5 CLK = ~CLK;

   int         total = 0;
   int         bad = 0;
   int         accepted = 0;
   int         starts = 0;
   logic       prev_busy = 1'b0;
   logic [1:0] exp_q[$];   // {tx, busy} per cycle

   // Frame as a list of line levels, each held p cycles; BUSY low only in the very last cycle.
   function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt,
                                      input logic [4:0] ps);
      int   p;
      int   n;
      int   idx;
      logic bits[$];
      p = (ps == 0) ? 1 : int'(ps);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pe) bits.push_back((^d) ^ pt);
      for (int i = 0; i < N_STOP; i++) bits.push_back(1'b1);
      n = bits.size() * p;
      idx = 0;
      foreach (bits[b]) begin
         for (int j = 0; j < p; j++) begin
            exp_q.push_back({bits[b], (idx == n - 1) ? 1'b0 : 1'b1});
            idx++;
         end
      end
   endfunction

   always @(negedge CLK) begin : monitor
      logic [1:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b10;
      total++;
      if ({TX_OUT, BUSY} !== e) begin
         bad++;
         $display("FAIL line t=%0t: tx,busy got %b,%b expected %b,%b", $time, TX_OUT, BUSY, e[1], e[0]);
      end
      if (BUSY === 1'b1 && prev_busy === 1'b0) starts++;
      prev_busy = BUSY;
   end

   // One cycle of stimulus; the model decides acceptance from its own expected BUSY.
   task automatic drive(input bit dv, input logic [7:0] d, input logic pe, input logic pt,
                        input logic [4:0] ps);
      @(posedge CLK);
      #1;
      DATA_VALID = dv;
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      PRESCALE   = ps;
      if (dv) begin
         if (exp_q.size() == 0) begin
            exp_q.push_back(2'b10);
            push_frame(d, pe, pt, ps);
            accepted++;
         end else if (exp_q[0][0] == 1'b0) begin
            push_frame(d, pe, pt, ps);
            accepted++;
         end
      end
   endtask

   task automatic noise(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
   endtask

   task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
      drive(1'b1, d, pe, pt, ps);
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < bound) begin
         noise(1);
         k++;
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL wait_idle: %0d cycles still pending after %0d, expected 0", exp_q.size(), bound);
         exp_q.delete();
      end
   endtask

   task automatic wait_release(input int bound);
      int k;
      k = 0;
      while (!(exp_q.size() == 0 || exp_q[0][0] == 1'b0) && k < bound) begin
         noise(1);
         k++;
      end
      if (k >= bound) begin
         total++;
         bad++;
         $display("FAIL wait_release: no release cycle within %0d cycles", bound);
      end
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      DATA_VALID = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      noise(3);

      send(8'h7A, 1'b1, 1'b0, 5'd8);
      wait_idle(400);
      send(8'h7B, 1'b0, 1'b0, 5'd8);
      wait_idle(400);
      send(8'h7A, 1'b1, 1'b1, 5'd8);
      wait_idle(400);

      for (int f = 0; f < 9; f++) begin
         wait_release(400);
         send(8'h7A, 1'b1, 1'b0, 5'd8);
      end
      wait_idle(400);

      send(8'h7A, 1'b1, 1'b0, 5'd8);
      noise(33);
      drive(1'b1, 8'h55, 1'b0, 1'b1, 5'd3);
      wait_idle(400);

      send(8'h3C, 1'b1, 1'b0, 5'd4);
      noise(15);
      do_reset();
      noise(2);
      send(8'hA5, 1'b1, 1'b1, 5'd4);
      wait_idle(400);

      send(8'h7A, 1'b1, 1'b0, 5'd0);
      wait_idle(100);
      send(8'hC3, 1'b1, 1'b0, 5'd31);
      wait_idle(1000);

      for (int r = 0; r < 40; r++) begin
         noise($urandom_range(0, 12));
         if ($urandom_range(0, 3) == 0) wait_release(400);
         send(8'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 6)));
         if ($urandom_range(0, 2) == 0) begin
            noise($urandom_range(1, 10));
            send(8'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 6)));
         end
      end
      wait_idle(2000);
      noise(3);

      total++;
      if (starts != accepted) begin
         bad++;
         $display("FAIL frame_count: frames started %0d, accepted by model %0d", starts, accepted);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
